// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - state encoding and select-width helper shared by the mux arbiter files
package mux_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Select width for a DEPTH:1 mux; never narrower than one bit so DEPTH=1 still has a select port.
    function automatic int sel_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/grant/handshake bundle for mux_rr_arbiter (lockIn present under MUX_ARB_LOCK_EN)
interface mux_rr_arbiter_if
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = sel_width(DEPTH)
);
    logic [DEPTH-1:0]     reqIn;
    logic                 outReady;
`ifdef MUX_ARB_LOCK_EN
    logic                 lockIn;
`endif
    logic [SEL_WIDTH-1:0] select;
    logic [DEPTH-1:0]     grantOut;
    logic                 outValid;
    logic [DEPTH-1:0]     ackOut;

`ifdef MUX_ARB_LOCK_EN
    modport master (
        input  reqIn, outReady, lockIn,
        output select, grantOut, outValid, ackOut
    );
    modport slave (
        output reqIn, outReady, lockIn,
        input  select, grantOut, outValid, ackOut
    );
`else
    modport master (
        input  reqIn, outReady,
        output select, grantOut, outValid, ackOut
    );
    modport slave (
        output reqIn, outReady,
        input  select, grantOut, outValid, ackOut
    );
`endif

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - combinational round-robin pick: lowest set index at or above ptr, else lowest below
module rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = sel_width(DEPTH)
) (
    input  logic [DEPTH-1:0]     reqMasked,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx,
    output logic [DEPTH-1:0]     onehot
);

    logic                 hi_found;
    logic                 lo_found;
    logic [SEL_WIDTH-1:0] hi_idx;
    logic [SEL_WIDTH-1:0] lo_idx;

    // Scan top-down so the lowest candidate in each half (>= ptr, < ptr) is the one left standing.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (reqMasked[i]) begin
                if ((SEL_WIDTH+1)'(i) >= {1'b0, ptr}) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_WIDTH'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_WIDTH'(i);
                end
            end
        end
    end

    assign found  = hi_found | lo_found;
    assign idx    = hi_found ? hi_idx : lo_idx;
    assign onehot = found ? (DEPTH'(1) << idx) : '0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with registered mux select and valid/ready output (lock bursts under MUX_ARB_LOCK_EN)
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = sel_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.master bus
);

    localparam logic [SEL_WIDTH:0] DEPTH_W = (SEL_WIDTH+1)'(DEPTH);

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [SEL_WIDTH-1:0] sel_d;
    logic [SEL_WIDTH-1:0] ptr_q;
    logic [SEL_WIDTH-1:0] ptr_d;
    logic [DEPTH-1:0]     grant_q;
    logic [DEPTH-1:0]     grant_d;

    logic [SEL_WIDTH:0]   sel_plus1;
    logic [SEL_WIDTH-1:0] ptr_inc;
    logic [DEPTH-1:0]     pick_req;
    logic [SEL_WIDTH-1:0] pick_ptr;
    logic                 pick_found;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic [DEPTH-1:0]     pick_onehot;

    logic                 accept;
    logic                 held;
    logic                 lock_now;
    logic                 keep;

`ifdef MUX_ARB_LOCK_EN
    assign lock_now = bus.lockIn;
`else
    assign lock_now = 1'b0;
`endif

    assign accept = (state_q == ST_GRANT) && bus.outReady;
    assign held   = |(bus.reqIn & grant_q);
    // A lock only extends a burst while the owner is still requesting; a dropped request rotates normally.
    assign keep   = lock_now && held;

    // Pointer one past the current grant, wrapped in SEL_WIDTH+1 bits so non-power-of-two DEPTH wraps at DEPTH.
    assign sel_plus1 = {1'b0, sel_q} + (SEL_WIDTH+1)'(1);
    assign ptr_inc   = (sel_plus1 >= DEPTH_W) ? '0 : sel_plus1[SEL_WIDTH-1:0];

    // In GRANT the picker previews the post-accept arbitration: served requester masked, pointer advanced.
    always_comb begin
        if (state_q == ST_GRANT) begin
            pick_req = bus.reqIn & ~grant_q;
            pick_ptr = ptr_inc;
        end else begin
            pick_req = bus.reqIn;
            pick_ptr = ptr_q;
        end
    end

    rr_pick #(
        .DEPTH     (DEPTH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .reqMasked (pick_req),
        .ptr       (pick_ptr),
        .found     (pick_found),
        .idx       (pick_idx),
        .onehot    (pick_onehot)
    );

    // State register plus the select/grant/pointer registers that feed the mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Next state: accept re-arbitrates back-to-back, no accept holds unless the owner let go.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = pick_found ? ST_GRANT : ST_IDLE;
            ST_GRANT: begin
                if (accept) begin
                    state_d = (keep || pick_found) ? ST_GRANT : ST_IDLE;
                end else begin
                    state_d = held ? ST_GRANT : ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next select/grant/pointer; select is left as-is whenever the grant goes idle.
    always_comb begin
        sel_d   = sel_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    grant_d = pick_onehot;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    if (!keep) begin
                        ptr_d   = ptr_inc;
                        grant_d = pick_onehot;
                        if (pick_found) sel_d = pick_idx;
                    end
                end else if (!held) begin
                    grant_d = '0;
                end
            end
            default: grant_d = '0;
        endcase
    end

    assign bus.select   = sel_q;
    assign bus.grantOut = grant_q;
    assign bus.outValid = (state_q == ST_GRANT);
    assign bus.ackOut   = accept ? grant_q : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter at DEPTH=4 and DEPTH=5
module tb_mux_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic l5;
    int   n_cmp = 0;
    int   n_bad = 0;

    mux_rr_arbiter_if #(.DEPTH(4)) b4 ();
    mux_rr_arbiter_if #(.DEPTH(5)) b5 ();

    mux_rr_arbiter #(.DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux_rr_arbiter #(.DEPTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

`ifdef MUX_ARB_LOCK_EN
    assign b4.lockIn = 1'b0;
    assign b5.lockIn = l5;
`endif

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int sel;
        int ptr;
    } mstate_t;

    mstate_t m [2];

    // Round-robin search: first requester met walking forward from ptr, modulo depth.
    function automatic int mpick(input int depth, input logic [7:0] req, input int ptr);
        int j;
        for (int k = 0; k < depth; k++) begin
            j = (ptr + k) % depth;
            if (req[j[2:0]]) return j;
        end
        return -1;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int depth, input logic [7:0] req,
                                      input logic rdy, input logic lock);
        mstate_t n;
        int      p;
        logic    own;
        n   = s;
        own = req[s.sel[2:0]];
        if (!s.v) begin
            p = mpick(depth, req, s.ptr);
            if (p >= 0) begin
                n.v   = 1'b1;
                n.sel = p;
            end
        end else if (rdy) begin
            if (!(lock && own)) begin
                n.ptr = (s.sel + 1) % depth;
                p = mpick(depth, req & ~(8'd1 << s.sel), n.ptr);
                if (p >= 0) n.sel = p;
                else        n.v = 1'b0;
            end
        end else if (!own) begin
            n.v = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] <= '{v: 1'b0, sel: 0, ptr: 0};
            m[1] <= '{v: 1'b0, sel: 0, ptr: 0};
        end else begin
            m[0] <= mstep(m[0], 4, 8'(b4.reqIn), b4.outReady, 1'b0);
            m[1] <= mstep(m[1], 5, 8'(b5.reqIn), b5.outReady, l5);
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, inst, act, exp);
        end
    endtask

    task automatic cmp_inst(input int inst, input mstate_t s, input logic [31:0] sel, input logic [7:0] grant,
                            input logic valid, input logic [7:0] ack, input logic rdy);
        logic [7:0] eg;
        eg = s.v ? (8'd1 << s.sel) : 8'd0;
        chk("model valid", inst, 32'(valid), 32'(s.v));
        chk("model grant", inst, 32'(grant), 32'(eg));
        chk("model ack", inst, 32'(ack), (s.v && rdy) ? 32'(eg) : 32'd0);
        if (s.v) chk("model select", inst, sel, 32'(s.sel));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, m[0], 32'(b4.select), 8'(b4.grantOut), b4.outValid, 8'(b4.ackOut), b4.outReady);
        cmp_inst(1, m[1], 32'(b5.select), 8'(b5.grantOut), b5.outValid, 8'(b5.ackOut), b5.outReady);
    end

    task automatic lit(input string name, input int inst, input int sel, input logic [7:0] grant,
                       input logic valid, input logic [7:0] ack);
        logic [31:0] a_sel;
        logic [7:0]  a_g;
        logic [7:0]  a_a;
        logic        a_v;
        if (inst == 0) begin
            a_sel = 32'(b4.select); a_g = 8'(b4.grantOut); a_a = 8'(b4.ackOut); a_v = b4.outValid;
        end else begin
            a_sel = 32'(b5.select); a_g = 8'(b5.grantOut); a_a = 8'(b5.ackOut); a_v = b5.outValid;
        end
        chk({name, " valid"}, inst, 32'(a_v), 32'(valid));
        chk({name, " grant"}, inst, 32'(a_g), 32'(grant));
        chk({name, " ack"}, inst, 32'(a_a), 32'(ack));
        if (valid) chk({name, " select"}, inst, a_sel, 32'(sel));
    endtask

    task automatic cyc(input logic [3:0] r4, input logic y4, input logic [4:0] r5, input logic y5, input logic lk);
        @(posedge clk);
        #1;
        b4.reqIn    = r4;
        b4.outReady = y4;
        b5.reqIn    = r5;
        b5.outReady = y5;
        l5          = lk;
        @(negedge clk);
    endtask

    initial begin
        logic lk;
        rst_n       = 1'b0;
        b4.reqIn    = '0;
        b4.outReady = 1'b0;
        b5.reqIn    = '0;
        b5.outReady = 1'b0;
        l5          = 1'b0;

        cyc(4'b1111, 1'b0, 5'b00000, 1'b0, 1'b0);
        lit("reset", 0, 0, 8'h00, 1'b0, 8'h00);
        lit("reset", 1, 0, 8'h00, 1'b0, 8'h00);
        chk("reset select", 0, 32'(b4.select), 32'd0);
        chk("reset select", 1, 32'(b5.select), 32'd0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        lit("released", 0, 0, 8'h00, 1'b0, 8'h00);

        cyc(4'b1111, 1'b0, 5'b00000, 1'b0, 1'b0);
        lit("first grant", 0, 0, 8'h01, 1'b1, 8'h00);

        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, 1'b1, 5'b00000, 1'b0, 1'b0);
            lit("rotation", 0, k % 4, 8'(1 << (k % 4)), 1'b1, 8'(1 << (k % 4)));
        end

        for (int k = 0; k < 5; k++) begin
            cyc(4'b0110, 1'b0, 5'b00000, 1'b0, 1'b0);
            lit("backpressure", 0, 1, 8'h02, 1'b1, 8'h00);
        end
        cyc(4'b0110, 1'b1, 5'b00000, 1'b0, 1'b0);
        lit("bp accept", 0, 1, 8'h02, 1'b1, 8'h02);
        cyc(4'b0110, 1'b0, 5'b00000, 1'b0, 1'b0);
        lit("after bp", 0, 2, 8'h04, 1'b1, 8'h00);

        cyc(4'b0010, 1'b0, 5'b00000, 1'b0, 1'b0);
        lit("owner drops", 0, 2, 8'h04, 1'b1, 8'h00);
        cyc(4'b0000, 1'b0, 5'b00000, 1'b0, 1'b0);
        lit("violation", 0, 0, 8'h00, 1'b0, 8'h00);
        cyc(4'b0100, 1'b0, 5'b00000, 1'b0, 1'b0);
        lit("rerequest", 0, 0, 8'h00, 1'b0, 8'h00);
        cyc(4'b0100, 1'b1, 5'b00000, 1'b0, 1'b0);
        lit("regrant", 0, 2, 8'h04, 1'b1, 8'h04);

        cyc(4'b1000, 1'b1, 5'b00000, 1'b0, 1'b0);
        lit("single bubble", 0, 0, 8'h00, 1'b0, 8'h00);
        cyc(4'b1000, 1'b1, 5'b00000, 1'b0, 1'b0);
        lit("single 3", 0, 3, 8'h08, 1'b1, 8'h08);
        cyc(4'b1001, 1'b1, 5'b00000, 1'b0, 1'b0);
        lit("wrap bubble", 0, 0, 8'h00, 1'b0, 8'h00);
        cyc(4'b1001, 1'b1, 5'b00000, 1'b0, 1'b0);
        lit("wrap picks 0", 0, 0, 8'h01, 1'b1, 8'h01);
        cyc(4'b1001, 1'b0, 5'b00000, 1'b0, 1'b0);
        lit("then 3", 0, 3, 8'h08, 1'b1, 8'h00);
        cyc(4'b0000, 1'b1, 5'b00000, 1'b0, 1'b0);
        lit("drain", 0, 3, 8'h08, 1'b1, 8'h08);

        cyc(4'b0000, 1'b0, 5'b10000, 1'b1, 1'b0);
        lit("d5 idle", 1, 0, 8'h00, 1'b0, 8'h00);
        cyc(4'b0000, 1'b0, 5'b10001, 1'b1, 1'b0);
        lit("d5 grant 4", 1, 4, 8'h10, 1'b1, 8'h10);
        cyc(4'b0000, 1'b0, 5'b10001, 1'b1, 1'b0);
        lit("d5 wrap 0", 1, 0, 8'h01, 1'b1, 8'h01);
`ifdef MUX_ARB_LOCK_EN
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0000, 1'b0, 5'b10001, 1'b1, 1'b1);
            lit("lock beat", 1, 4, 8'h10, 1'b1, 8'h10);
        end
        cyc(4'b0000, 1'b0, 5'b10001, 1'b1, 1'b0);
        lit("lock release", 1, 4, 8'h10, 1'b1, 8'h10);
        cyc(4'b0000, 1'b0, 5'b10001, 1'b0, 1'b0);
        lit("after lock", 1, 0, 8'h01, 1'b1, 8'h00);
`else
        cyc(4'b0000, 1'b0, 5'b10001, 1'b0, 1'b0);
        lit("d5 back to 4", 1, 4, 8'h10, 1'b1, 8'h00);
`endif

        for (int k = 0; k < 300; k++) begin
            lk = 1'b0;
`ifdef MUX_ARB_LOCK_EN
            lk = 1'($urandom_range(0, 1));
`endif
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), lk);
        end

        cyc(4'b1111, 1'b0, 5'b11111, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        lit("async reset", 0, 0, 8'h00, 1'b0, 8'h00);
        lit("async reset", 1, 0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'b0000, 1'b0, 5'b00000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 5'b00000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
